fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage. Sits directly upstream of `control`.
- Holds the PC and issues one request at a time to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched word, its PC and its opcode field to decode with a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from execute and discards any in-flight stale fetch.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; always equals pc_q.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  execute requests a PC change.
- redirect_target  in  XLEN  new PC.
- instr_valid  out  1  instr_out holds a valid instruction.
- instr_ready  in  1  decode consumes the instruction this cycle.
- instr_out  out  32  instruction word.
- instr_pc  out  XLEN  PC of instr_out.
- instr_opcode  out  7  instr_out[6:0]; drives control.instr.

Behaviour:
- Reset (async assert, sync release):
  - State REQ, pc_q = RESET_PC.
  - instr_valid = 0, instr_out = 32'h0000_0013 (NOP), instr_pc = 0, kill flag = 0.
- FSM states: REQ, WAIT, FLUSH, HOLD.
  - REQ: imem_req = 1. imem_gnt → WAIT.
  - WAIT: imem_req = 0. On imem_rvalid: capture imem_rdata into instr_out and pc_q into instr_pc, set instr_valid = 1, → HOLD.
  - FLUSH: imem_req = 0. On imem_rvalid: drop the data, → REQ.
  - HOLD: instr_valid = 1.
    - instr_ready: clear instr_valid, pc_q ← pc_q + 4, → REQ.
    - !instr_ready: instr_out and instr_pc stay stable.
- imem_rvalid outside WAIT/FLUSH is ignored. This covers responses arriving after reset mid-operation.
- Only one request is outstanding at any time.
- Minimum latency, request to instr_valid:
  - gnt in the request cycle and rvalid the next cycle → instr_valid is visible 2 cycles after the request cycle.
  - Steady-state throughput is 1 instruction per 3 cycles with zero-wait memory.
- Redirect has priority over all other events in the same cycle:
  - pc_q ← {redirect_target[XLEN-1:2], 2'b00}. Misaligned low bits are forced to 0; no exception.
  - instr_valid ← 0. A simultaneous instr_ready is ignored.
  - Next state:
    - WAIT → FLUSH.
    - REQ with imem_gnt the same cycle → FLUSH.
    - FLUSH with imem_rvalid the same cycle → REQ.
    - REQ without gnt, FLUSH without rvalid, HOLD → REQ or stay FLUSH as applicable. Outstanding stale data is never delivered.
- pc_q + 4 wraps modulo 2^XLEN; no overflow flag.
- imem_addr changes only in REQ entry cycles. It is stable while imem_req = 1 and !imem_gnt, except on redirect.

Decomposition:
- Shared package riscv_pkg:
  - XLEN.
  - Opcode constants: BTYPE, RTYPE, STORE, LOAD, ITYPE, JAL, JALR.
  - NOP encoding 32'h0000_0013.
  - fetch_state_t enum {REQ, WAIT, FLUSH, HOLD}.
- No sub-module; PC register, FSM and output register fit in one module.

Test Plan:
- Reset then zero-wait memory (gnt with req, rvalid next cycle), rdata = 0x00500093, instr_ready = 1:
  - Expect imem_addr = 0, then instr_valid with instr_pc = 0, instr_opcode = 7'b0010011.
  - Next imem_addr = 4.
- Decode stall: instr_ready = 0 for 5 cycles in HOLD → instr_out/instr_pc are stable and imem_req = 0. Release ready → next fetch at PC+4.
- Gnt delay: imem_gnt withheld 3 cycles → imem_req stays 1 and imem_addr stays 0x8.
- Redirect to 0x100 while in WAIT for PC 0x8 → stale rvalid data (0xDEADBEEF) never appears on instr_out. Next imem_addr = 0x100.
- Redirect with target 0x203 in the same cycle as instr_ready in HOLD:
  - instr_valid drops.
  - Next imem_addr = 0x200, not PC+4.
- Async rst asserted mid-WAIT:
  - Outputs return to reset values immediately (instr_valid = 0, instr_out = NOP).
  - A late rvalid after release is ignored.
  - First request is to RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : riscv_pkg                                             |
// | Purpose  : Shared widths, opcode constants, NOP encoding and     |
// |            the fetch FSM state type.                             |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package riscv_pkg;

  localparam int XLEN = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] BTYPE = 7'b1100011;
  localparam logic [6:0] RTYPE = 7'b0110011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] ITYPE = 7'b0010011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fetch_unit                                            |
// | Purpose  : Instruction fetch stage. One outstanding imem request, |
// |            valid/ready output to decode, redirect with stale-     |
// |            response flushing.                                    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      instr_opcode
);
  import riscv_pkg::*;

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] r_instr_pc;
  logic [31:0]     r_instr;
  logic            r_valid;
  logic            w_capture;
  logic            w_release;
  logic            w_req;
  logic            w_unused_target_lsbs;

  // Redirect targets are word-aligned by dropping the low bits
  assign w_unused_target_lsbs = ^redirect_target[1:0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= REQ;
    else     r_state <= w_state_next;
  end

  // Next state, request strobe, capture/release strobes and next PC
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    w_req        = 1'b0;
    case (r_state)
      REQ: begin
        w_req = 1'b1;
        // A grant together with a redirect makes the response stale
        if (imem_gnt) w_state_next = redirect_valid ? FLUSH : WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          // If the response lands in the redirect cycle it is already
          // consumed here, so nothing remains outstanding to flush
          w_state_next = imem_rvalid ? REQ : FLUSH;
        end else if (imem_rvalid) begin
          w_capture    = 1'b1;
          w_state_next = HOLD;
        end
      end
      FLUSH: begin
        if (imem_rvalid) w_state_next = REQ;
      end
      HOLD: begin
        if (redirect_valid) begin
          w_state_next = REQ;
        end else if (instr_ready) begin
          w_release    = 1'b1;
          w_pc_next    = r_pc + XLEN'(4);
          w_state_next = REQ;
        end
      end
      default: w_state_next = REQ;
    endcase
    if (redirect_valid) w_pc_next = {redirect_target[XLEN-1:2], 2'b00};
  end

  // PC, instruction output register and valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_instr    <= NOP;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_capture)                        r_valid <= 1'b1;
      else if (w_release || redirect_valid) r_valid <= 1'b0;
    end
  end

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign instr_valid  = r_valid;
  assign instr_out    = r_instr;
  assign instr_pc     = r_instr_pc;
  assign instr_opcode = r_instr[6:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                         |
// | Purpose  : Self-checking bench for fetch_unit: directed scenarios |
// |            plus randomized memory/redirect/decode traffic against |
// |            a transaction-level reference model.                  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_target = '0;
  logic            instr_valid;
  logic            instr_ready = 1'b0;
  logic [31:0]     instr_out;
  logic [XLEN-1:0] instr_pc;
  logic [6:0]      instr_opcode;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_opcode   (instr_opcode)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: PC, one outstanding-request slot with a stale bit,
  // and an output slot holding the delivered instruction
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_stale;
  bit          m_have;
  logic [31:0] m_data;
  logic [31:0] m_ipc;

  // Memory responder state for the random phase
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_out   = 1'b0;
    m_stale = 1'b0;
    m_have  = 1'b0;
    m_data  = NOP_WORD;
    m_ipc   = '0;
  endtask

  // Advance the model across one clock edge given this cycle's inputs
  task automatic model_step(input bit g, input bit rv, input logic [31:0] rd,
                            input bit re, input logic [31:0] tg, input bit rdy);
    bit          req;
    bit          n_out;
    bit          n_stale;
    bit          n_have;
    logic [31:0] n_pc;
    req     = !m_out && !m_have;
    n_out   = m_out;
    n_stale = m_stale;
    n_have  = m_have;
    n_pc    = m_pc;
    if (m_out && rv) begin
      n_out = 1'b0;
      if (!m_stale && !re) begin
        n_have = 1'b1;
        m_data = rd;
        m_ipc  = m_pc;
      end
    end
    if (req && g) begin
      n_out   = 1'b1;
      n_stale = re;
    end else if (n_out && re) begin
      n_stale = 1'b1;
    end
    if (m_have && rdy && !re) begin
      n_have = 1'b0;
      n_pc   = m_pc + 32'd4;
    end
    if (re) begin
      n_have = 1'b0;
      n_pc   = tg & 32'hFFFF_FFFC;
    end
    m_pc    = n_pc;
    m_out   = n_out;
    m_stale = n_stale;
    m_have  = n_have;
  endtask

  // One clock: drive inputs at the falling edge, advance the model, and
  // return shortly after the rising edge for literal checks
  task automatic step(input bit g, input bit rv, input logic [31:0] rd,
                      input bit re, input logic [31:0] tg, input bit rdy);
    @(negedge clk);
    imem_gnt        = g;
    imem_rvalid     = rv;
    imem_rdata      = rd;
    redirect_valid  = re;
    redirect_target = tg;
    instr_ready     = rdy;
    model_step(g, rv, rd, re, tg, rdy);
    @(posedge clk);
    #3;
  endtask

  task automatic idle_inputs();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_target = '0; instr_ready = 1'b0;
  endtask

  // Compare process: every cycle out of reset, DUT against the model
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      check("imem_req",     32'(imem_req),     32'(!m_out && !m_have));
      check("imem_addr",    imem_addr,         m_pc);
      check("instr_valid",  32'(instr_valid),  32'(m_have));
      check("instr_out",    instr_out,         m_data);
      check("instr_pc",     instr_pc,          m_ipc);
      check("instr_opcode", 32'(instr_opcode), 32'(m_data[6:0]));
    end
  end

  initial begin
    bit          g;
    bit          rv;
    bit          re;
    bit          rdy;
    logic [31:0] rd;
    logic [31:0] tg;

    model_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_req",   32'(imem_req),    32'd1);
    check("reset_addr",  imem_addr,        32'h0);
    check("reset_valid", 32'(instr_valid), 32'd0);
    check("reset_instr", instr_out,        32'h0000_0013);
    check("reset_pc",    instr_pc,         32'h0);

    // Zero-wait fetch of addi x1,x0,5 at PC 0
    step(1, 0, 0, 0, 0, 0);
    check("wait_req", 32'(imem_req), 32'd0);
    step(0, 1, 32'h0050_0093, 0, 0, 0);
    check("first_valid",  32'(instr_valid),  32'd1);
    check("first_pc",     instr_pc,          32'h0);
    check("first_opcode", 32'(instr_opcode), 32'h13);
    step(0, 0, 0, 0, 0, 1);
    check("next_addr_4", imem_addr, 32'h4);

    // Decode stall for five cycles
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0010_0113, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    check("stall_instr", instr_out,      32'h0010_0113);
    check("stall_pc",    instr_pc,       32'h4);
    check("stall_req",   32'(imem_req),  32'd0);
    step(0, 0, 0, 0, 0, 1);
    check("after_stall_addr", imem_addr, 32'h8);

    // Grant withheld three cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("gnt_delay_req",  32'(imem_req), 32'd1);
      check("gnt_delay_addr", imem_addr,     32'h8);
    end

    // Redirect while waiting for PC 8; stale data must be dropped
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h100, 0);
    check("flush_addr", imem_addr, 32'h100);
    step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    check("flush_valid", 32'(instr_valid), 32'd0);
    check("flush_instr", instr_out,        32'h0010_0113);
    check("flush_req",   32'(imem_req),    32'd1);

    // Misaligned redirect coinciding with instr_ready in HOLD
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0513, 0, 0, 0);
    check("hold_pc_100", instr_pc, 32'h100);
    step(0, 0, 0, 1, 32'h203, 1);
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_addr",  imem_addr,        32'h200);

    // PC wraps modulo 2^32
    step(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0033, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset in WAIT, late response after release
    step(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    check("async_valid", 32'(instr_valid), 32'd0);
    check("async_instr", instr_out,        32'h0000_0013);
    check("async_pc",    instr_pc,         32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 32'h0BAD_0BAD, 0, 0, 0);
    check("late_valid", 32'(instr_valid), 32'd0);
    check("late_instr", instr_out,        32'h0000_0013);
    check("late_req",   32'(imem_req),    32'd1);
    check("late_addr",  imem_addr,        RESET_PC);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0073, 0, 0, 0);
    check("post_reset_pc", instr_pc, 32'h0);

    // Randomized traffic: variable memory latency, stray responses,
    // random redirects (including misaligned) and decode back-pressure
    for (int n = 0; n < 3000; n++) begin
      rv = 1'b0;
      rd = $urandom;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          rv       = 1'b1;
          rd       = mem_word(mem_addr);
          mem_busy = 1'b0;
        end else begin
          mem_cnt--;
        end
      end else if ($urandom_range(15) == 0) begin
        rv = 1'b1;
      end
      g   = ($urandom_range(9) < 6);
      re  = ($urandom_range(11) == 0);
      tg  = $urandom;
      rdy = ($urandom_range(9) < 7);
      if (!m_out && !m_have && g) begin
        mem_busy = 1'b1;
        mem_addr = m_pc;
        mem_cnt  = $urandom_range(3);
      end
      step(g, rv, rd, re, tg, rdy);
    end

    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
